// File: rtl/bzmusic_arbiter.sv
// bzmusic_arbiter
// Shares one buzzer music player between N_REQ sound requesters (jump, coin,
// crash, background loop, ...). Requests are latched into a pending mask. The
// highest pending index wins and drives the player's song select, start pulse
// and reset. After the song-done pulse a silence gap is inserted before the
// next arbitration. Also handles preemption, looping, cancel, mute and a
// watchdog.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   req          per-requester request; any high cycle sets the pending bit
//   cancel       per-requester cancel; clears pending, aborts the active song
//   mute         level; blocks new grants and aborts the current song
//   player_done  one-cycle end-of-song pulse from the player
//   song_sel     index of the granted requester (song ROM base select)
//   player_en    one-cycle start pulse to the player
//   player_rstn  active-low reset to the player / tune PWM / beat counter
//   busy         high in LOAD, START and PLAY
//   grant        one-hot active requester, zero when not busy
//   done         one-cycle pulse on natural completion of a requester's song
//   aborted      one-cycle pulse when a requester's song is cut short
module bzmusic_arbiter #(
  parameter int                 N_REQ      = 4,
  parameter int                 PREEMPT    = 1,
  parameter logic [N_REQ-1:0]   LOOP_MASK  = 4'b0001,
  parameter int                 GAP_CYCLES = 1000,
  parameter int                 TIMEOUT    = 500000000,
  parameter int                 CNT_W      = 32,
  localparam int                SEL_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   cancel,
  input  logic               mute,
  input  logic               player_done,
  output logic [SEL_W-1:0]   song_sel,
  output logic               player_en,
  output logic               player_rstn,
  output logic               busy,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int              GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [N_REQ-1:0] pend;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] winner;
  logic [N_REQ-1:0] win_mask;
  logic [N_REQ-1:0] act_mask;
  logic [N_REQ-1:0] above_active;
  logic             stop_req;
  logic             preempt_hit;
  logic             take_grant;
  logic             loop_set;
  logic [N_REQ-1:0] pend_next;

  // Highest set bit of a mask; later (higher) indices overwrite earlier ones.
  function automatic logic [SEL_W-1:0] top_idx(input logic [N_REQ-1:0] v);
    top_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) top_idx = SEL_W'(i);
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (SEL_W'(i) == idx) onehot[i] = 1'b1;
    end
  endfunction

  // Requesters strictly more important than the one currently playing.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_above
      assign above_active[gi] = (SEL_W'(gi) > song_sel);
    end
  endgenerate

  always_comb begin
    winner      = top_idx(pend);
    win_mask    = onehot(winner);
    act_mask    = onehot(song_sel);
    stop_req    = mute | cancel[song_sel];
    preempt_hit = (PREEMPT != 0) && (|(pend & above_active));
    take_grant  = ((state == IDLE) && (|pend) && !mute) ||
                  ((state == PLAY) && !stop_req && preempt_hit);
    loop_set    = (state == PLAY) && !stop_req && !preempt_hit &&
                  player_done && LOOP_MASK[song_sel];
    // Grant clear first, then sets (so a same-cycle request survives the
    // clear), and cancel last so it overrides everything.
    pend_next   = ((pend & ~(take_grant ? win_mask : '0)) | req |
                   (loop_set ? act_mask : '0)) & ~cancel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= '0;
      cnt         <= '0;
      song_sel    <= '0;
      player_en   <= 1'b0;
      player_rstn <= 1'b0;
      busy        <= 1'b0;
      grant       <= '0;
      done        <= '0;
      aborted     <= '0;
    end else begin
      pend      <= pend_next;
      player_en <= 1'b0;
      done      <= '0;
      aborted   <= '0;

      case (state)
        IDLE: begin
          player_rstn <= 1'b0;
          if (take_grant) begin
            state    <= LOAD;
            song_sel <= winner;
            grant    <= win_mask;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          state       <= START;
          player_rstn <= 1'b1;
          player_en   <= 1'b1;
        end

        START: begin
          state <= PLAY;
          cnt   <= '0;
        end

        PLAY: begin
          if (stop_req) begin
            aborted     <= act_mask;
            state       <= GAP;
            cnt         <= '0;
            player_rstn <= 1'b0;
            busy        <= 1'b0;
            grant       <= '0;
          end else if (preempt_hit) begin
            // Straight back to LOAD: the player is reset for one cycle and
            // restarted on the new song without a silence gap.
            aborted     <= act_mask;
            state       <= LOAD;
            song_sel    <= winner;
            grant       <= win_mask;
            player_rstn <= 1'b0;
          end else if (player_done) begin
            done        <= act_mask;
            state       <= GAP;
            cnt         <= '0;
            player_rstn <= 1'b0;
            busy        <= 1'b0;
            grant       <= '0;
          end else if (cnt == TO_LAST) begin
            aborted     <= act_mask;
            state       <= GAP;
            cnt         <= '0;
            player_rstn <= 1'b0;
            busy        <= 1'b0;
            grant       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          player_rstn <= 1'b0;
          grant       <= '0;
          busy        <= 1'b0;
          if ((GAP_CYCLES == 0) || (cnt == GAP_LAST)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          player_rstn <= 1'b0;
          busy        <= 1'b0;
          grant       <= '0;
        end
      endcase
    end
  end

endmodule
